nibble_serial_addsub: RTL and testbench

NIBBLE_SERIAL_ADDSUB -- requirements
Module: nibble_serial_addsub

---
 rtl/nibble_serial_addsub_if.sv | 23 ++
 rtl/nibble_serial_addsub.sv | 89 ++++++++
 tb/tb_nibble_serial_addsub.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_addsub_if.sv
// Operand/result bundle for the nibble-serial add/subtract unit.
// master drives the request side; slave is the arithmetic block.
interface nibble_serial_addsub_if;
   logic        start;
   logic        subt;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        cout;
   logic        overflow;

   modport master (
      output start, subt, a, b,
      input  busy, done, result, cout, overflow
   );

   modport slave (
      input  start, subt, a, b,
      output busy, done, result, cout, overflow
   );
endinterface

// File: rtl/nibble_serial_addsub.sv
// 16-bit add/subtract through one 4-bit adder, LS nibble first; done 4 edges after accept, then IDLE.
// No backpressure: start is only sampled in IDLE, and requests arriving in RUN/DONE are dropped.
module nibble_serial_addsub (
   input  logic                   clk,
   input  logic                   rst,
   nibble_serial_addsub_if.slave  io
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q, state_d;
   logic        accept;
   logic [15:0] a_q, b_q;
   logic        subt_q;
   logic        carry_q;
   logic [1:0]  idx_q;
   logic [15:0] result_q;
   logic        cout_q, overflow_q;

   logic [3:0]  a_nib, b_nib;
   logic [4:0]  nib_sum;
   logic        carry_into_msb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: if (io.start) begin
            state_d = RUN;
            accept  = 1'b1;
         end
         RUN:  if (idx_q == 2'd3) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Subtraction is a + ~b + 1; the +1 rides in on carry_q loaded at accept.
   assign a_nib          = a_q[{idx_q, 2'b00} +: 4];
   assign b_nib          = b_q[{idx_q, 2'b00} +: 4] ^ {4{subt_q}};
   assign nib_sum        = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
   assign carry_into_msb = a_nib[3] ^ b_nib[3] ^ nib_sum[3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         subt_q     <= 1'b0;
         carry_q    <= 1'b0;
         idx_q      <= 2'd0;
         result_q   <= '0;
         cout_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else if (accept) begin
         a_q        <= io.a;
         b_q        <= io.b;
         subt_q     <= io.subt;
         carry_q    <= io.subt;
         idx_q      <= 2'd0;
         result_q   <= '0;
         cout_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else if (state_q == RUN) begin
         result_q[{idx_q, 2'b00} +: 4] <= nib_sum[3:0];
         carry_q <= nib_sum[4];
         // Index parks at 3 on the last nibble; the DONE transition does the wrap.
         if (idx_q == 2'd3) begin
            cout_q     <= nib_sum[4];
            overflow_q <= carry_into_msb ^ nib_sum[4];
         end else begin
            idx_q <= idx_q + 2'd1;
         end
      end else if (state_q == DONE) begin
         idx_q <= 2'd0;
      end
   end

   assign io.busy     = (state_q == RUN);
   assign io.done     = (state_q == DONE);
   assign io.result   = result_q;
   assign io.cout     = cout_q;
   assign io.overflow = overflow_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed-vector bench for nibble_serial_addsub; inputs driven and outputs sampled on the falling edge.
module tb_nibble_serial_addsub;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   nibble_serial_addsub_if bus ();

   nibble_serial_addsub dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   always #5 clk = ~clk;

   // Waits for IDLE, issues one operation, scrambles the inputs after accept,
   // and reports how many edges after the accept edge done appeared (-1 if never).
   task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                         output int done_edges, output int busy_cnt);
      int guard;
      guard = 0;
      while ((bus.busy || bus.done) && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      bus.a     = av;
      bus.b     = bv;
      bus.subt  = sv;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = ~av;
      bus.b     = ~bv;
      bus.subt  = ~sv;
      done_edges = -1;
      busy_cnt   = 0;
      for (int n = 1; n <= 10; n++) begin
         if (bus.busy) busy_cnt++;
         @(posedge clk);
         @(negedge clk);
         if (bus.done) begin
            done_edges = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #1;
      n_cmp++; if (bus.result !== 16'h0000) begin n_bad++; $display("FAIL reset_result got=%h want=0000", bus.result); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
      n_cmp++; if ({bus.cout, bus.overflow} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got=%b%b want=00", bus.cout, bus.overflow); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add;
      int de, bc;
      run_op(16'h1234, 16'h0FCC, 1'b0, de, bc);
      n_cmp++; if (de !== 4) begin n_bad++; $display("FAIL add_latency got=%0d want=4", de); end
      n_cmp++; if (bc !== 4) begin n_bad++; $display("FAIL add_busy_cycles got=%0d want=4", bc); end
      n_cmp++; if (bus.result !== 16'h2200) begin n_bad++; $display("FAIL add_result got=%h want=2200", bus.result); end
      n_cmp++; if ({bus.cout, bus.overflow} !== 2'b00) begin n_bad++; $display("FAIL add_flags got=%b%b want=00", bus.cout, bus.overflow); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL add_busy_in_done got=%b want=0", bus.busy); end
      @(negedge clk);
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL add_done_width got=%b want=0", bus.done); end
      n_cmp++; if (bus.result !== 16'h2200) begin n_bad++; $display("FAIL add_result_hold got=%h want=2200", bus.result); end
   endtask

   task automatic test_sub;
      int de, bc;
      run_op(16'h0005, 16'h0007, 1'b1, de, bc);
      n_cmp++; if (de !== 4) begin n_bad++; $display("FAIL sub_latency got=%0d want=4", de); end
      n_cmp++; if (bus.result !== 16'hFFFE) begin n_bad++; $display("FAIL sub_result got=%h want=fffe", bus.result); end
      n_cmp++; if ({bus.cout, bus.overflow} !== 2'b00) begin n_bad++; $display("FAIL sub_flags got=%b%b want=00", bus.cout, bus.overflow); end
   endtask

   task automatic test_boundaries;
      int de, bc;
      run_op(16'h7FFF, 16'h0001, 1'b0, de, bc);
      n_cmp++; if (bus.result !== 16'h8000) begin n_bad++; $display("FAIL pos_ovf_result got=%h want=8000", bus.result); end
      n_cmp++; if ({bus.cout, bus.overflow} !== 2'b01) begin n_bad++; $display("FAIL pos_ovf_flags got=%b%b want=01", bus.cout, bus.overflow); end
      run_op(16'hFFFF, 16'h0001, 1'b0, de, bc);
      n_cmp++; if (bus.result !== 16'h0000) begin n_bad++; $display("FAIL wrap_result got=%h want=0000", bus.result); end
      n_cmp++; if ({bus.cout, bus.overflow} !== 2'b10) begin n_bad++; $display("FAIL wrap_flags got=%b%b want=10", bus.cout, bus.overflow); end
   endtask

   task automatic test_sub_overflow;
      int de, bc;
      run_op(16'h8000, 16'h0001, 1'b1, de, bc);
      n_cmp++; if (bus.result !== 16'h7FFF) begin n_bad++; $display("FAIL neg_ovf_result got=%h want=7fff", bus.result); end
      n_cmp++; if ({bus.cout, bus.overflow} !== 2'b11) begin n_bad++; $display("FAIL neg_ovf_flags got=%b%b want=11", bus.cout, bus.overflow); end
   endtask

   task automatic test_back_to_back;
      int guard;
      guard = 0;
      while ((bus.busy || bus.done) && guard < 20) begin @(negedge clk); guard++; end
      bus.a = 16'h1111; bus.b = 16'h2222; bus.subt = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      guard = 0;
      @(negedge clk);
      while (!bus.done && guard < 10) begin
         bus.a = bus.a + 16'h0F0F;
         bus.b = bus.b ^ 16'hA5A5;
         bus.subt = ~bus.subt;
         @(negedge clk);
         guard++;
      end
      n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL b2b_first_done got=%b want=1", bus.done); end
      n_cmp++; if (bus.result !== 16'h3333) begin n_bad++; $display("FAIL b2b_first_result got=%h want=3333", bus.result); end
      bus.a = 16'h0101; bus.b = 16'h0202; bus.subt = 1'b0;
      @(negedge clk);
      n_cmp++; if ({bus.busy, bus.done} !== 2'b00) begin n_bad++; $display("FAIL b2b_idle_gap got=%b%b want=00", bus.busy, bus.done); end
      @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_reaccept got=%b want=1", bus.busy); end
      n_cmp++; if (bus.result !== 16'h0000) begin n_bad++; $display("FAIL b2b_result_cleared got=%h want=0000", bus.result); end
      guard = 0;
      while (!bus.done && guard < 10) begin
         bus.a = bus.a ^ 16'hFFFF;
         bus.b = bus.b + 16'h1234;
         @(negedge clk);
         guard++;
      end
      bus.start = 1'b0;
      n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL b2b_second_done got=%b want=1", bus.done); end
      n_cmp++; if (bus.result !== 16'h0303) begin n_bad++; $display("FAIL b2b_second_result got=%h want=0303", bus.result); end
   endtask

   task automatic test_rst_mid_run;
      int guard, done_seen, de, bc;
      guard = 0;
      while ((bus.busy || bus.done) && guard < 20) begin @(negedge clk); guard++; end
      bus.a = 16'h1234; bus.b = 16'h0FCC; bus.subt = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rst_pre_busy got=%b want=1", bus.busy); end
      rst = 1'b1;
      #1;
      n_cmp++; if ({bus.busy, bus.done} !== 2'b00) begin n_bad++; $display("FAIL rst_async_status got=%b%b want=00", bus.busy, bus.done); end
      n_cmp++; if ({bus.result, bus.cout, bus.overflow} !== 18'h0) begin n_bad++; $display("FAIL rst_async_outputs got=%h/%b%b want=0000/00", bus.result, bus.cout, bus.overflow); end
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.done) done_seen++;
         if (i == 2) rst = 1'b0;
      end
      n_cmp++; if (done_seen !== 0) begin n_bad++; $display("FAIL rst_no_done got=%0d want=0", done_seen); end
      run_op(16'h1234, 16'h0FCC, 1'b0, de, bc);
      n_cmp++; if (de !== 4) begin n_bad++; $display("FAIL rst_fresh_latency got=%0d want=4", de); end
      n_cmp++; if (bus.result !== 16'h2200) begin n_bad++; $display("FAIL rst_fresh_result got=%h want=2200", bus.result); end
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      clk       = 1'b0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.subt  = 1'b0;
      bus.a     = 16'h0000;
      bus.b     = 16'h0000;
      test_reset;
      test_add;
      test_sub;
      test_boundaries;
      test_sub_overflow;
      test_back_to_back;
      test_rst_mid_run;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
